lut_sweep_eval: RTL and testbench

//  Parametrised N-input Boolean function evaluator. The truth table is loaded

---
 rtl/lut_sweep_eval_if.sv | 25 ++
 rtl/lut_sweep_eval.sv | 90 +++++++++
 tb/tb_lut_sweep_eval.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lut_sweep_eval_if.sv
// Handshake/data bundle for lut_sweep_eval: live/sweep controls in, result and status out.
interface lut_sweep_eval_if #(
  parameter int N = 3
) ();
  logic [N-1:0]      x;
  logic              mode;
  logic              start;
  logic              load_en;
  logic              load_bit;
  logic              z;
  logic [N-1:0]      vec;
  logic              busy;
  logic              done;
  logic [(1<<N)-1:0] sig;

  modport slave (
    input  x, mode, start, load_en, load_bit,
    output z, vec, busy, done, sig
  );

  modport master (
    output x, mode, start, load_en, load_bit,
    input  z, vec, busy, done, sig
  );
endinterface

// File: rtl/lut_sweep_eval.sv
// Run-time loadable N-input truth table with a registered output and a
// self-sweeping engine that records every table entry into a signature.
module lut_sweep_eval #(
  parameter int N           = 3,
  parameter int STEP_CYCLES = 10
) (
  input  logic            clk,
  input  logic            rst,
  lut_sweep_eval_if.slave io
);
  localparam int D  = 1 << N;
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   tt_q, tt_d;
  logic [D-1:0]   sig_q, sig_d;
  logic [N-1:0]   vec_q, vec_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           z_q, z_d;
  logic           step_end, last_vec;

  assign step_end = (cnt_q == CW'(STEP_CYCLES - 1));
  assign last_vec = (vec_q == {N{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tt_q    <= '0;
      sig_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      sig_q   <= sig_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tt_d    = tt_q;
    sig_d   = sig_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        z_d   = tt_q[io.x];
        vec_d = '0;
        if (io.load_en) tt_d = {tt_q[D-2:0], io.load_bit};
        if (io.start && io.mode) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        z_d = tt_q[vec_q];
        if (step_end) begin
          // z_q already reflects tt[vec_q]: vec has been stable for >=1 cycle
          cnt_d        = '0;
          sig_d[vec_q] = z_q;
          if (last_vec) state_d = DONE;
          else          vec_d   = vec_q + N'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        z_d     = tt_q[vec_q];
        vec_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.busy = (state_q == RUN);
    io.done = (state_q == DONE);
    io.z    = z_q;
    io.vec  = vec_q;
    io.sig  = sig_q;
  end
endmodule

// File: tb/tb_lut_sweep_eval.sv
// Randomised bench for lut_sweep_eval against a sweep-time-index reference model,
// plus directed checks of the parity and OR tables.
module tb_lut_sweep_eval;
  localparam int N   = 3;
  localparam int S   = 10;
  localparam int D   = 1 << N;
  localparam int TOT = D * S;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lut_sweep_eval_if #(.N(3)) b1 ();
  lut_sweep_eval_if #(.N(4)) b2 ();

  lut_sweep_eval #(.N(3), .STEP_CYCLES(10)) dut1 (.clk(clk), .rst(rst), .io(b1));
  lut_sweep_eval #(.N(4), .STEP_CYCLES(2))  dut2 (.clk(clk), .rst(rst), .io(b2));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_p is the time index within a sweep (-1 idle, 0..TOT-1 running, TOT done cycle).
  logic [D-1:0] m_tt, m_sig;
  logic         m_z, m_nz;
  int           m_p, m_ap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tt = '0; m_sig = '0; m_z = 1'b0; m_p = -1;
    end else begin
      if (m_p < 0)         m_ap = int'(b1.x);
      else if (m_p >= TOT) m_ap = D - 1;
      else                 m_ap = m_p / S;
      m_nz = m_tt[m_ap];
      if (m_p >= 0 && m_p < TOT && (m_p % S) == S - 1) m_sig[m_p / S] = m_z;
      if (m_p < 0 && b1.load_en) m_tt = {m_tt[D-2:0], b1.load_bit};
      if (m_p < 0) begin
        if (b1.start && b1.mode) m_p = 0;
      end else if (m_p < TOT) m_p++;
      else m_p = -1;
      m_z = m_nz;
    end
  end

  int exp_vec;
  always @(negedge clk) begin
    if (!rst) begin
      exp_vec = (m_p < 0) ? 0 : (m_p >= TOT) ? D - 1 : m_p / S;
      chk("z",    b1.z,    m_z);
      chk("vec",  b1.vec,  exp_vec);
      chk("busy", b1.busy, (m_p >= 0 && m_p < TOT));
      chk("done", b1.done, (m_p == TOT));
      chk("sig",  b1.sig,  m_sig);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic b);
    b1.load_en = 1'b1; b1.load_bit = b;
    tick();
    b1.load_en = 1'b0;
  endtask

  // noise: 0 quiet, 1 one burst at vec==3, 2 random inputs on every busy cycle
  task automatic sweep1(input int noise, output int bc, output int dc);
    bit hit;
    hit = 0; bc = 0; dc = 0;
    b1.mode = 1'b1; b1.start = 1'b1;
    tick();
    b1.start = 1'b0; b1.mode = 1'b0;
    for (int i = 0; i < TOT + 20; i++) begin
      if (b1.busy) bc++;
      if (b1.done) dc++;
      b1.start = 1'b0; b1.mode = 1'b0; b1.load_en = 1'b0;
      if (b1.busy && !b1.done) begin
        if (noise == 1 && b1.vec == 3'd3 && !hit) begin
          b1.start = 1'b1; b1.mode = 1'b1; b1.load_en = 1'b1; b1.load_bit = 1'b1;
          hit = 1;
        end else if (noise == 2) begin
          b1.start = 1'($urandom); b1.mode = 1'($urandom);
          b1.load_en = 1'($urandom); b1.load_bit = 1'($urandom);
          b1.x = 3'($urandom);
        end
      end
      if (dc > 0 && !b1.done) break;
      tick();
    end
    b1.start = 1'b0; b1.mode = 1'b0; b1.load_en = 1'b0;
  endtask

  int bc, dc, bc2;
  logic [3:0]  pv2;
  logic [15:0] or_tt;
  logic [7:0]  par_bits;

  initial begin
    b1.x = '0; b1.mode = 0; b1.start = 0; b1.load_en = 0; b1.load_bit = 0;
    b2.x = '0; b2.mode = 0; b2.start = 0; b2.load_en = 0; b2.load_bit = 0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst0_z", b1.z, 0); chk("rst0_vec", b1.vec, 0); chk("rst0_busy", b1.busy, 0);
    chk("rst0_done", b1.done, 0); chk("rst0_sig", b1.sig, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Parity table, MSB entry first
    par_bits = 8'b1001_0110;
    for (int i = 7; i >= 0; i--) load1(par_bits[i]);
    chk("model_tt_parity", m_tt, 8'h96);
    b1.x = 3'b011; tick(); chk("live_x011", b1.z, 0);
    b1.x = 3'b111; tick(); chk("live_x111", b1.z, 1);
    b1.x = 3'b001; tick(); chk("live_x001", b1.z, 1);

    // Plain sweep
    sweep1(0, bc, dc);
    chk("sweep_busy_cycles", bc, 80); chk("sweep_done_pulses", dc, 1);
    chk("sweep_sig", b1.sig, 8'h96);  chk("sweep_vec_idle", b1.vec, 0);
    tick();

    // Mid-sweep noise at vec 3
    sweep1(1, bc, dc);
    chk("noise_busy_cycles", bc, 80); chk("noise_done_pulses", dc, 1);
    chk("noise_sig", b1.sig, 8'h96);  chk("noise_model_tt", m_tt, 8'h96);
    tick(); tick(); chk("noise_no_restart", b1.busy, 0);

    // Reset mid-sweep at vec 4
    b1.mode = 1'b1; b1.start = 1'b1; tick(); b1.start = 1'b0; b1.mode = 1'b0;
    for (int i = 0; i < TOT && b1.vec != 3'd4; i++) tick();
    chk("reached_vec4", b1.vec, 4);
    #2 rst = 1'b1;
    #1;
    chk("mrst_z", b1.z, 0); chk("mrst_vec", b1.vec, 0); chk("mrst_busy", b1.busy, 0);
    chk("mrst_done", b1.done, 0); chk("mrst_sig", b1.sig, 0); chk("mrst_model_tt", m_tt, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_no_done", b1.done, 0);
    sweep1(0, bc, dc);
    chk("zero_busy_cycles", bc, 80); chk("zero_sig", b1.sig, 8'h00);
    tick();

    // Randomised load / live / noisy-sweep rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'($urandom_range(12, 0)); i++) begin
        b1.x = 3'($urandom);
        load1(1'($urandom));
      end
      for (int i = 0; i < 6; i++) begin
        b1.x = 3'($urandom);
        b1.load_en = 1'($urandom); b1.load_bit = 1'($urandom);
        tick();
      end
      b1.load_en = 1'b0;
      sweep1(2, bc, dc);
      chk("rand_busy_cycles", bc, 80); chk("rand_done_pulses", dc, 1);
      chk("rand_sig_eq_tt", b1.sig, m_tt);
      tick();
    end

    // N=4, STEP_CYCLES=2: OR function
    or_tt = 16'hFFFE;
    for (int i = 15; i >= 0; i--) begin
      b2.load_en = 1'b1; b2.load_bit = or_tt[i]; tick();
    end
    b2.load_en = 1'b0; b2.x = '0;
    tick();
    pv2 = b2.vec;
    b2.mode = 1'b1; b2.start = 1'b1; tick(); b2.start = 1'b0; b2.mode = 1'b0;
    bc2 = 0;
    for (int i = 0; i < 60 && b2.busy; i++) begin
      bc2++;
      chk("or_z_vs_vec", b2.z, (pv2 != 4'd0));
      pv2 = b2.vec;
      tick();
    end
    chk("or_busy_cycles", bc2, 32); chk("or_done", b2.done, 1);
    chk("or_sig", b2.sig, 16'hFFFE);
    tick();
    chk("or_vec_idle", b2.vec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
